// File: rtl/revaluate_seq_cu.sv
// revaluate_seq_cu -- multi-pass evaluation sequencer.
// On start it runs NUM_PASSES passes of READ -> START -> COUNT (-> NEXT),
// then pulses done for one cycle. Each COUNT phase ends when datapath_done
// is seen or when TIMEOUT_CYCLES cycles elapse, which ends the sequence
// with the sticky timeout_err flag set.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             sequence request (IDLE only)
//   datapath_done     current pass finished (COUNT only)
//   abort             cancel sequence, back to IDLE without done
//   dataset_reset     high in IDLE
//   read              high in READ
//   write             high in START and COUNT
//   count             high in COUNT
//   done              one-cycle pulse in DONE
//   busy              high in every state except IDLE
//   pass_idx          zero-based index of the current pass
//   timeout_err       sticky: last sequence ended by timeout
module revaluate_seq_cu #(
   parameter int NUM_PASSES     = 4,
   parameter int READ_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic                                datapath_done,
   input  logic                                abort,
   output logic                                dataset_reset,
   output logic                                read,
   output logic                                write,
   output logic                                count,
   output logic                                done,
   output logic                                busy,
   output logic [$clog2(NUM_PASSES+1)-1:0]     pass_idx,
   output logic                                timeout_err
);

   localparam int PW = $clog2(NUM_PASSES + 1);
   localparam logic [PW-1:0] PASS_LAST = PW'(NUM_PASSES - 1);
   localparam logic [7:0]    READ_LAST = 8'(READ_CYCLES - 1);
   localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      START,
      COUNT,
      NEXT,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pass_idx_q, pass_idx_d;
   logic            timeout_err_q, timeout_err_d;
   logic [7:0]      dwell_q, dwell_d;
   logic [15:0]     tmo_q, tmo_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pass_idx_q    <= '0;
         timeout_err_q <= 1'b0;
         dwell_q       <= '0;
         tmo_q         <= '0;
      end else begin
         state_q       <= state_d;
         pass_idx_q    <= pass_idx_d;
         timeout_err_q <= timeout_err_d;
         dwell_q       <= dwell_d;
         tmo_q         <= tmo_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      pass_idx_d    = pass_idx_q;
      timeout_err_d = timeout_err_q;
      dwell_d       = dwell_q;
      tmo_d         = tmo_q;

      // abort outranks every other transition; pass_idx and timeout_err hold
      if (state_q != IDLE && abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               // start together with abort is treated as no request
               if (start && !abort) begin
                  state_d       = READ;
                  pass_idx_d    = '0;
                  timeout_err_d = 1'b0;
                  dwell_d       = '0;
               end
            end
            READ: begin
               if (dwell_q == READ_LAST) begin
                  state_d = START;
               end else begin
                  dwell_d = dwell_q + 8'd1;
               end
            end
            START: begin
               state_d = COUNT;
               tmo_d   = '0;
            end
            COUNT: begin
               // datapath_done wins over a timeout expiring in the same cycle
               if (datapath_done) begin
                  state_d = (pass_idx_q == PASS_LAST) ? DONE : NEXT;
               end else if (tmo_q == TMO_LAST) begin
                  state_d       = DONE;
                  timeout_err_d = 1'b1;
               end else begin
                  tmo_d = tmo_q + 16'd1;
               end
            end
            NEXT: begin
               pass_idx_d = pass_idx_q + PW'(1);
               dwell_d    = '0;
               state_d    = READ;
            end
            DONE: begin
               state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign dataset_reset = (state_q == IDLE);
   assign read          = (state_q == READ);
   assign write         = (state_q == START) || (state_q == COUNT);
   assign count         = (state_q == COUNT);
   assign done          = (state_q == DONE);
   assign busy          = (state_q != IDLE);
   assign pass_idx      = pass_idx_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_revaluate_seq_cu.sv
// Directed bench for revaluate_seq_cu using three parameterisations:
//   A: defaults (4 passes, READ 1, timeout 255)
//   B: 1 pass, READ 3, timeout 4
//   C: 4 passes, READ 1, timeout 8
// Output vectors are {dataset_reset, read, write, count, done, busy}.
module tb_revaluate_seq_cu;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic a_start = 0, a_dd = 0, a_abort = 0;
   logic a_dsr, a_rd, a_wr, a_cnt, a_done, a_busy, a_terr;
   logic [2:0] a_pass;
   logic b_start = 0, b_dd = 0, b_abort = 0;
   logic b_dsr, b_rd, b_wr, b_cnt, b_done, b_busy, b_terr;
   logic [0:0] b_pass;
   logic c_start = 0, c_dd = 0, c_abort = 0;
   logic c_dsr, c_rd, c_wr, c_cnt, c_done, c_busy, c_terr;
   logic [2:0] c_pass;

   logic [5:0] a_o, b_o, c_o;
   assign a_o = {a_dsr, a_rd, a_wr, a_cnt, a_done, a_busy};
   assign b_o = {b_dsr, b_rd, b_wr, b_cnt, b_done, b_busy};
   assign c_o = {c_dsr, c_rd, c_wr, c_cnt, c_done, c_busy};

   localparam logic [5:0] O_IDLE  = 6'b100000;
   localparam logic [5:0] O_READ  = 6'b010001;
   localparam logic [5:0] O_START = 6'b001001;
   localparam logic [5:0] O_COUNT = 6'b001101;
   localparam logic [5:0] O_NEXT  = 6'b000001;
   localparam logic [5:0] O_DONE  = 6'b000011;

   revaluate_seq_cu u_a (
      .clk(clk), .rst(rst), .start(a_start), .datapath_done(a_dd), .abort(a_abort),
      .dataset_reset(a_dsr), .read(a_rd), .write(a_wr), .count(a_cnt), .done(a_done),
      .busy(a_busy), .pass_idx(a_pass), .timeout_err(a_terr));

   revaluate_seq_cu #(.NUM_PASSES(1), .READ_CYCLES(3), .TIMEOUT_CYCLES(4)) u_b (
      .clk(clk), .rst(rst), .start(b_start), .datapath_done(b_dd), .abort(b_abort),
      .dataset_reset(b_dsr), .read(b_rd), .write(b_wr), .count(b_cnt), .done(b_done),
      .busy(b_busy), .pass_idx(b_pass), .timeout_err(b_terr));

   revaluate_seq_cu #(.NUM_PASSES(4), .READ_CYCLES(1), .TIMEOUT_CYCLES(8)) u_c (
      .clk(clk), .rst(rst), .start(c_start), .datapath_done(c_dd), .abort(c_abort),
      .dataset_reset(c_dsr), .read(c_rd), .write(c_wr), .count(c_cnt), .done(c_done),
      .busy(c_busy), .pass_idx(c_pass), .timeout_err(c_terr));

   int n_cmp = 0;
   int n_err = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One B sequence; k = COUNT cycle on which datapath_done is given (0 = never).
   // cyc is the cycle (READ = 1) in which done is seen, -1 if it never came.
   task automatic run_b(input int k, output int rd, output int wr, output int cyc);
      int cc;
      rd = 0; wr = 0; cc = 0; cyc = -1;
      b_start = 1; tick; b_start = 0;
      for (int i = 1; i <= 40; i++) begin
         if (b_done) begin
            cyc = i;
            break;
         end
         if (b_rd) rd++;
         if (b_wr) wr++;
         if (b_cnt) begin
            cc++;
            b_dd = (k != 0) && (cc == k);
         end
         tick;
      end
      b_dd = 0;
      tick;
   endtask

   int rd, wr, cyc;

   initial begin
      // reset state
      tick; tick;
      rst = 0;
      chk("rst_a_out", int'(a_o), int'(O_IDLE));
      chk("rst_b_out", int'(b_o), int'(O_IDLE));
      chk("rst_c_out", int'(c_o), int'(O_IDLE));
      chk("rst_a_pass", int'(a_pass), 0);
      chk("rst_a_terr", int'(a_terr), 0);

      // four passes, datapath_done on 3rd COUNT cycle, start held during COUNT
      a_start = 1; tick; a_start = 0;
      for (int p = 0; p < 4; p++) begin
         chk("a_read", int'(a_o), int'(O_READ));
         chk("a_pass", int'(a_pass), p);
         tick; chk("a_start_st", int'(a_o), int'(O_START));
         tick; chk("a_count", int'(a_o), int'(O_COUNT));
         a_start = 1;
         tick; tick;
         chk("a_count3", int'(a_o), int'(O_COUNT));
         a_dd = 1; a_start = 0;
         tick; a_dd = 0;
         if (p < 3) begin
            chk("a_next", int'(a_o), int'(O_NEXT));
            tick;
         end else begin
            chk("a_done", int'(a_o), int'(O_DONE));
            chk("a_done_terr", int'(a_terr), 0);
         end
      end
      tick; chk("a_idle_after", int'(a_o), int'(O_IDLE));
      chk("a_pass_held", int'(a_pass), 3);
      tick; chk("a_no_retrigger", int'(a_o), int'(O_IDLE));

      // abort in COUNT of pass 2
      a_start = 1; tick; a_start = 0;
      for (int p = 0; p < 2; p++) begin
         tick; tick; a_dd = 1; tick; a_dd = 0; tick;
      end
      tick; tick;
      chk("ab_count", int'(a_o), int'(O_COUNT));
      chk("ab_pass_pre", int'(a_pass), 2);
      a_abort = 1; tick; a_abort = 0;
      chk("ab_idle", int'(a_o), int'(O_IDLE));
      chk("ab_pass", int'(a_pass), 2);
      chk("ab_terr", int'(a_terr), 0);
      tick; chk("ab_no_done", int'(a_o), int'(O_IDLE));

      // start with abort in IDLE is ignored
      a_start = 1; a_abort = 1; tick; a_start = 0; a_abort = 0;
      chk("sa_idle", int'(a_o), int'(O_IDLE));
      chk("sa_pass", int'(a_pass), 2);

      // C: timeout after 8 COUNT cycles
      c_start = 1; tick; c_start = 0;
      chk("c_read", int'(c_o), int'(O_READ));
      tick; tick;
      for (int i = 0; i < 8; i++) begin
         chk("c_count", int'(c_o), int'(O_COUNT));
         tick;
      end
      chk("c_done", int'(c_o), int'(O_DONE));
      chk("c_terr_done", int'(c_terr), 1);
      chk("c_pass", int'(c_pass), 0);
      tick; chk("c_idle", int'(c_o), int'(O_IDLE));
      tick; chk("c_terr_sticky", int'(c_terr), 1);

      // reset during READ of pass 1
      a_start = 1; tick; a_start = 0;
      tick; tick; a_dd = 1; tick; a_dd = 0; tick;
      chk("rr_read", int'(a_o), int'(O_READ));
      chk("rr_pass1", int'(a_pass), 1);
      rst = 1; tick; rst = 0;
      chk("rr_out", int'(a_o), int'(O_IDLE));
      chk("rr_pass", int'(a_pass), 0);
      chk("rr_c_terr", int'(c_terr), 0);
      tick; chk("rr_stay", int'(a_o), int'(O_IDLE));

      // B: single pass, READ 3, done on COUNT cycle 2
      run_b(2, rd, wr, cyc);
      chk("b2_read_cycles", rd, 3);
      chk("b2_write_cycles", wr, 3);
      chk("b2_latency", cyc, 7);
      chk("b2_terr", int'(b_terr), 0);
      chk("b2_idle", int'(b_o), int'(O_IDLE));

      // B: datapath_done on the timeout cycle wins
      run_b(4, rd, wr, cyc);
      chk("b4_write_cycles", wr, 5);
      chk("b4_latency", cyc, 9);
      chk("b4_terr", int'(b_terr), 0);

      // B: no datapath_done -> timeout
      run_b(0, rd, wr, cyc);
      chk("bt_write_cycles", wr, 5);
      chk("bt_latency", cyc, 9);
      chk("bt_terr", int'(b_terr), 1);

      // next accepted start clears the sticky flag
      b_start = 1; tick; b_start = 0;
      chk("bt_clear", int'(b_terr), 0);
      b_abort = 1; tick; b_abort = 0;
      chk("b_abort_idle", int'(b_o), int'(O_IDLE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
